// File: rtl/alu_mc_if.sv
// Request/result handshake bundle between the issue stage, alu_mc and the writeback arbiter.
interface alu_mc_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_opcode;
  logic [2:0]        in_funct;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_overflow;
  logic              out_err;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_opcode, in_funct, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_err, out_tag
  );

  modport slave (
    input  in_valid, in_opcode, in_funct, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_err, out_tag
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arith/logic/compare/shift, bit-serial MUL/CLMUL and CRC,
// one operation in flight, valid/ready on both sides with a tag sideband.
module alu_mc #(
  parameter int DATA_W = 32,
  parameter int KEY_W  = 8,
  parameter int TAG_W  = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     abort,
  output logic     busy,
  alu_mc_if.slave  bus
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = SH_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  localparam logic [3:0] OP_ADDSUB = 4'd0;
  localparam logic [3:0] OP_LOGIC  = 4'd1;
  localparam logic [3:0] OP_CMP    = 4'd2;
  localparam logic [3:0] OP_SHIFT  = 4'd3;
  localparam logic [3:0] OP_MUL    = 4'd9;
  localparam logic [3:0] OP_CRC    = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic              in_ready_w;
  logic              accept;
  logic              is_iter;
  logic              load_single;
  logic              load_iter;
  logic              step;
  logic              finish;

  logic [DATA_W-1:0]   result_q;
  logic                overflow_q;
  logic                err_q;
  logic [TAG_W-1:0]    tag_q;

  logic                op_crc;
  logic [1:0]          op_funct;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   a_sh;
  logic [KEY_W-1:0]    crc;
  logic [KEY_W-1:0]    key;

  logic [DATA_W-1:0]        sc_result;
  logic                     sc_overflow;
  logic                     sc_err;
  logic [DATA_W-1:0]        sum;
  logic [2*DATA_W-1:0]      dbl;
  logic signed [DATA_W-1:0] sra;
  logic                     cmp;
  logic [SH_W-1:0]          amt;

  logic [2*DATA_W-1:0] pp;
  logic [2*DATA_W-1:0] acc_next;
  logic                crc_d;
  logic                crc_fb;
  logic [KEY_W-1:0]    crc_next;
  logic [DATA_W-1:0]   crc_ext;
  logic [DATA_W-1:0]   iter_result;

  assign in_ready_w = rst & ~abort &
                      ((state == IDLE) | ((state == DONE) & bus.out_ready));
  assign accept     = bus.in_valid & in_ready_w;
  assign is_iter    = (bus.in_opcode == OP_MUL) | (bus.in_opcode == OP_CRC);

  assign bus.in_ready     = in_ready_w;
  assign bus.out_valid    = (state == DONE);
  assign bus.out_result   = result_q;
  assign bus.out_overflow = overflow_q;
  assign bus.out_err      = err_q;
  assign bus.out_tag      = tag_q;
  assign busy             = (state != IDLE);

  assign amt = bus.in_b[SH_W-1:0];

  always_comb begin
    sc_result   = '0;
    sc_overflow = 1'b0;
    sc_err      = 1'b0;
    sum         = '0;
    dbl         = '0;
    cmp         = 1'b0;
    sra         = $signed(bus.in_a) >>> amt;
    case (bus.in_opcode)
      OP_ADDSUB: begin
        sum       = bus.in_funct[0] ? (bus.in_a - bus.in_b) : (bus.in_a + bus.in_b);
        sc_result = sum;
        // SUB overflows when operand signs differ, ADD when they agree; either way the sign flips.
        if (bus.in_funct[0])
          sc_overflow = (bus.in_a[DATA_W-1] != bus.in_b[DATA_W-1]) &&
                        (sum[DATA_W-1] != bus.in_a[DATA_W-1]);
        else
          sc_overflow = (bus.in_a[DATA_W-1] == bus.in_b[DATA_W-1]) &&
                        (sum[DATA_W-1] != bus.in_a[DATA_W-1]);
      end
      OP_LOGIC: begin
        case (bus.in_funct)
          3'd0:    sc_result = bus.in_a & bus.in_b;
          3'd1:    sc_result = bus.in_a | bus.in_b;
          3'd2:    sc_result = bus.in_a ^ bus.in_b;
          3'd3:    sc_result = ~(bus.in_a | bus.in_b);
          3'd4:    sc_result = bus.in_a & ~bus.in_b;
          default: sc_result = '0;
        endcase
      end
      OP_CMP: begin
        case (bus.in_funct)
          3'd0:    cmp = (bus.in_a == bus.in_b);
          3'd1:    cmp = (bus.in_a != bus.in_b);
          3'd2:    cmp = ($signed(bus.in_a) < $signed(bus.in_b));
          3'd3:    cmp = (bus.in_a < bus.in_b);
          3'd4:    cmp = ($signed(bus.in_a) >= $signed(bus.in_b));
          3'd5:    cmp = (bus.in_a >= bus.in_b);
          default: cmp = 1'b0;
        endcase
        sc_result = {{(DATA_W-1){1'b0}}, cmp};
      end
      OP_SHIFT: begin
        case (bus.in_funct)
          3'd0: sc_result = bus.in_a << amt;
          3'd1: sc_result = bus.in_a >> amt;
          3'd2: sc_result = sra;
          3'd3: begin
            dbl       = {bus.in_a, bus.in_a} << amt;
            sc_result = dbl[2*DATA_W-1:DATA_W];
          end
          3'd4: begin
            dbl       = {bus.in_a, bus.in_a} >> amt;
            sc_result = dbl[DATA_W-1:0];
          end
          default: sc_result = '0;
        endcase
      end
      OP_MUL, OP_CRC: sc_result = '0;
      default:        sc_err    = 1'b1;
    endcase
  end

  // One multiplier bit and one CRC data bit are consumed per BUSY cycle.
  always_comb begin
    pp       = mplier[0] ? mcand : '0;
    acc_next = op_funct[0] ? (acc ^ pp) : (acc + pp);
    crc_d    = op_funct[0] ? a_sh[0] : a_sh[DATA_W-1];
    crc_fb   = crc[KEY_W-1] ^ crc_d;
    crc_next = (crc << 1) ^ (crc_fb ? key : '0);
    crc_ext  = '0;
    crc_ext[KEY_W-1:0] = crc_next;
    if (op_crc)
      iter_result = crc_ext;
    else if (op_funct[1])
      iter_result = acc_next[2*DATA_W-1:DATA_W];
    else
      iter_result = acc_next[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Abort beats everything; a DONE with out_ready and a new request re-enters as from IDLE.
  always_comb begin
    state_next  = state;
    load_single = 1'b0;
    load_iter   = 1'b0;
    step        = 1'b0;
    finish      = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (is_iter) begin
              load_iter  = 1'b1;
              state_next = BUSY;
            end else begin
              load_single = 1'b1;
              state_next  = DONE;
            end
          end else if (state == DONE && bus.out_ready) begin
            state_next = IDLE;
          end
        end
        BUSY: begin
          step = 1'b1;
          if (cnt == LAST) begin
            finish     = 1'b1;
            state_next = DONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
      tag_q      <= '0;
      op_crc     <= 1'b0;
      op_funct   <= '0;
      cnt        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      a_sh       <= '0;
      crc        <= '0;
      key        <= '0;
    end else begin
      if (load_single) begin
        result_q   <= sc_result;
        overflow_q <= sc_overflow;
        err_q      <= sc_err;
        tag_q      <= bus.in_tag;
      end
      if (load_iter) begin
        tag_q    <= bus.in_tag;
        op_crc   <= (bus.in_opcode == OP_CRC);
        op_funct <= bus.in_funct[1:0];
        cnt      <= '0;
        mcand    <= {{DATA_W{1'b0}}, bus.in_a};
        mplier   <= bus.in_b;
        acc      <= '0;
        a_sh     <= bus.in_a;
        crc      <= '0;
        key      <= bus.in_b[KEY_W-1:0];
      end
      if (step) begin
        cnt    <= cnt + CNT_W'(1);
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        acc    <= acc_next;
        a_sh   <= op_funct[0] ? (a_sh >> 1) : (a_sh << 1);
        crc    <= crc_next;
      end
      if (finish) begin
        result_q   <= iter_result;
        overflow_q <= 1'b0;
        err_q      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: expected results are queued at accept and compared on transfer.
module tb_alu_mc;

  typedef struct packed {
    logic [31:0] result;
    logic        ovf;
    logic        err;
    logic [3:0]  tag;
  } expT;

  localparam longint MAXI = 64'sh0000_0000_7FFF_FFFF;
  localparam longint MINI = -64'sh0000_0000_8000_0000;

  logic clk;
  logic rst;
  logic abort;
  logic busy;

  int checkCount;
  int errorCount;

  expT sb[$];

  alu_mc_if #(.DATA_W(32), .TAG_W(4)) bus ();

  alu_mc #(.DATA_W(32), .KEY_W(8), .TAG_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .abort (abort),
    .busy  (busy),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic expT modelOp(input logic [3:0] op, input logic [2:0] funct,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] tag);
    expT e;
    longint sa, sbv, s;
    logic [63:0] p;
    logic [31:0] r;
    logic [7:0]  c;
    logic d, fb, bit1;
    int amt;
    e = '0;
    e.tag = tag;
    case (op)
      4'd0: begin
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        s   = funct[0] ? (sa - sbv) : (sa + sbv);
        e.result = s[31:0];
        e.ovf    = (s > MAXI) || (s < MINI);
      end
      4'd1: begin
        case (funct)
          3'd0: e.result = a & b;
          3'd1: e.result = a | b;
          3'd2: e.result = a ^ b;
          3'd3: e.result = ~(a | b);
          3'd4: e.result = a & ~b;
          default: e.result = 32'd0;
        endcase
      end
      4'd2: begin
        case (funct)
          3'd0: bit1 = (a == b);
          3'd1: bit1 = (a != b);
          3'd2: bit1 = ($signed(a) < $signed(b));
          3'd3: bit1 = (a < b);
          3'd4: bit1 = ($signed(a) >= $signed(b));
          3'd5: bit1 = (a >= b);
          default: bit1 = 1'b0;
        endcase
        e.result = {31'd0, bit1};
      end
      4'd3: begin
        amt = int'(b[4:0]);
        r = a;
        case (funct)
          3'd0: r = a << amt;
          3'd1: r = a >> amt;
          3'd2: for (int i = 0; i < amt; i++) r = {r[31], r[31:1]};
          3'd3: for (int i = 0; i < amt; i++) r = {r[30:0], r[31]};
          3'd4: for (int i = 0; i < amt; i++) r = {r[0], r[31:1]};
          default: r = 32'd0;
        endcase
        e.result = r;
      end
      4'd9: begin
        if (funct[0]) begin
          p = 64'd0;
          for (int i = 0; i < 32; i++)
            if (b[i]) p = p ^ ({32'd0, a} << i);
        end else begin
          p = {32'd0, a} * {32'd0, b};
        end
        e.result = funct[1] ? p[63:32] : p[31:0];
      end
      4'd10: begin
        c = 8'd0;
        for (int i = 0; i < 32; i++) begin
          d  = funct[0] ? a[i] : a[31-i];
          fb = c[7] ^ d;
          c  = (c << 1) ^ (fb ? b[7:0] : 8'd0);
        end
        e.result = {24'd0, c};
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic applyStimulus(input string name, input logic [3:0] op, input logic [2:0] funct,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] tag, input expT e);
    int waitCycles;
    bit acc;
    waitCycles = 0;
    acc = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_funct  = funct;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = tag;
    while (!acc && waitCycles < 100) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1'b1;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      waitCycles++;
    end
    bus.in_valid = 1'b0;
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
    checkOutput({name, "_accepted"}, 64'(acc), 64'd1);
  endtask

  task automatic waitResult(input string name, input int expLat, input bit chkBusy);
    int lat;
    bit seen;
    bit busyBad;
    lat = 0;
    seen = 1'b0;
    busyBad = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) seen = 1'b1;
      else if (chkBusy && (bus.in_ready || !busy)) busyBad = 1'b1;
      @(posedge clk);
      #1;
    end
    checkOutput({name, "_latency"}, 64'(lat), 64'(expLat));
    if (chkBusy) checkOutput({name, "_busy_no_ready"}, 64'(busyBad), 64'd0);
  endtask

  initial begin : monitor
    expT e;
    forever begin
      @(negedge clk);
      if (rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", 64'(bus.out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("result",   64'(bus.out_result),   64'(e.result));
          checkOutput("overflow", 64'(bus.out_overflow), 64'(e.ovf));
          checkOutput("err",      64'(bus.out_err),      64'(e.err));
          checkOutput("tag",      64'(bus.out_tag),      64'(e.tag));
        end
      end
    end
  end

  initial begin : stimulus
    logic [3:0]  op;
    logic [2:0]  fn;
    logic [31:0] a, b;
    bit seenValid;
    checkCount = 0;
    errorCount = 0;
    rst = 1'b0;
    abort = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_opcode = 4'd0;
    bus.in_funct  = 3'd0;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.in_tag    = 4'd0;
    bus.out_ready = 1'b1;

    #3;
    checkOutput("reset_out_valid", 64'(bus.out_valid),    64'd0);
    checkOutput("reset_result",    64'(bus.out_result),   64'd0);
    checkOutput("reset_overflow",  64'(bus.out_overflow), 64'd0);
    checkOutput("reset_err",       64'(bus.out_err),      64'd0);
    checkOutput("reset_tag",       64'(bus.out_tag),      64'd0);
    checkOutput("reset_busy",      64'(busy),             64'd0);
    #19 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("idle_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    applyStimulus("add_ovf", 4'd0, 3'd0, 32'h7FFF_FFFF, 32'd1, 4'd3, '{32'h8000_0000, 1'b1, 1'b0, 4'd3});
    waitResult("add_ovf", 1, 1'b0);
    @(negedge clk);
    checkOutput("add_then_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    applyStimulus("mulhu", 4'd9, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 4'd1});
    waitResult("mulhu", 33, 1'b1);
    applyStimulus("mullo", 4'd9, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, '{32'h0000_0001, 1'b0, 1'b0, 4'd2});
    waitResult("mullo", 33, 1'b1);
    applyStimulus("clmul", 4'd9, 3'd1, 32'd3, 32'd3, 4'd4, '{32'h0000_0005, 1'b0, 1'b0, 4'd4});
    waitResult("clmul", 33, 1'b1);

    applyStimulus("crc_1", 4'd10, 3'd0, 32'h0000_0001, 32'h0000_0007, 4'd5, '{32'h0000_0007, 1'b0, 1'b0, 4'd5});
    waitResult("crc_1", 33, 1'b1);
    applyStimulus("crc_80", 4'd10, 3'd0, 32'h0000_0080, 32'h0000_0007, 4'd6, '{32'h0000_0089, 1'b0, 1'b0, 4'd6});
    waitResult("crc_80", 33, 1'b1);

    // Backpressure then back-to-back accept on the releasing edge.
    bus.out_ready = 1'b0;
    applyStimulus("sub_bp", 4'd0, 3'd1, 32'd5, 32'd7, 4'd7, '{32'hFFFF_FFFE, 1'b0, 1'b0, 4'd7});
    waitResult("sub_bp", 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("bp_valid",    64'(bus.out_valid),  64'd1);
      checkOutput("bp_result",   64'(bus.out_result), 64'hFFFF_FFFE);
      checkOutput("bp_tag",      64'(bus.out_tag),    64'd7);
      checkOutput("bp_in_ready", 64'(bus.in_ready),   64'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    applyStimulus("xor_b2b", 4'd1, 3'd2, 32'h0000_00F0, 32'h0000_00FF, 4'd8, '{32'h0000_000F, 1'b0, 1'b0, 4'd8});
    waitResult("xor_b2b", 1, 1'b0);

    // Abort a CRC at cnt=10 while a new request is offered.
    applyStimulus("crc_abort", 4'd10, 3'd0, 32'h1234_5678, 32'h0000_0007, 4'd9,
                  modelOp(4'd10, 3'd0, 32'h1234_5678, 32'h0000_0007, 4'd9));
    repeat (10) @(posedge clk);
    #1;
    abort = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_opcode = 4'd0;
    bus.in_funct  = 3'd0;
    bus.in_a      = 32'd1;
    bus.in_b      = 32'd1;
    bus.in_tag    = 4'd10;
    @(negedge clk);
    checkOutput("abort_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    bus.in_valid = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    checkOutput("abort_busy",  64'(busy),          64'd0);
    checkOutput("abort_valid", 64'(bus.out_valid), 64'd0);
    seenValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) seenValid = 1'b1;
    end
    checkOutput("abort_no_result", 64'(seenValid), 64'd0);
    @(posedge clk); #1;

    applyStimulus("bad_op", 4'd15, 3'd0, 32'hDEAD_BEEF, 32'h1234_5678, 4'd11, '{32'd0, 1'b0, 1'b1, 4'd11});
    waitResult("bad_op", 1, 1'b0);

    for (int i = 0; i < 16; i++) begin
      op = 4'($urandom_range(0, 3));
      fn = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 4 == 0) ? a : $urandom;
      applyStimulus("rand_sc", op, fn, a, b, 4'(i), modelOp(op, fn, a, b, 4'(i)));
      waitResult("rand_sc", 1, 1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      op = (i < 4) ? 4'd9 : 4'd10;
      fn = (i < 4) ? 3'(i) : 3'(i - 4);
      a  = $urandom;
      b  = $urandom;
      applyStimulus("rand_iter", op, fn, a, b, 4'(i + 3), modelOp(op, fn, a, b, 4'(i + 3)));
      waitResult("rand_iter", 33, 1'b1);
    end

    // Async reset in the middle of a multiply.
    applyStimulus("mul_rst", 4'd9, 3'd2, 32'hCAFE_F00D, 32'h8765_4321, 4'd12,
                  modelOp(4'd9, 3'd2, 32'hCAFE_F00D, 32'h8765_4321, 4'd12));
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_mid_busy",   64'(busy),             64'd0);
    checkOutput("rst_mid_valid",  64'(bus.out_valid),    64'd0);
    checkOutput("rst_mid_result", 64'(bus.out_result),   64'd0);
    checkOutput("rst_mid_tag",    64'(bus.out_tag),      64'd0);
    checkOutput("rst_mid_err",    64'(bus.out_err),      64'd0);
    void'(sb.pop_back());
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    applyStimulus("post_rst_add", 4'd0, 3'd0, 32'd100, 32'd23, 4'd13, '{32'd123, 1'b0, 1'b0, 4'd13});
    waitResult("post_rst_add", 1, 1'b0);

    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the combinational ALU.
- Has a valid/ready handshake on both input and output, plus a tag sideband.
- Executes single-cycle ops (arith, logic, compare, shift) in one cycle, and iterative ops (multiply, CRC) at one bit per cycle.
- Sits between the issue stage and the writeback arbiter; one operation is in flight at a time.

Parameters:
- DATA_W, 32, operand/result width (>=8).
- KEY_W, 8, CRC polynomial width (2..DATA_W).
- TAG_W, 4, sideband tag width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- abort  in  1  synchronous flush of the in-flight op.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_opcode  in  4  operation class.
- in_funct  in  3  operation variant.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B / CRC key in [KEY_W-1:0].
- in_tag  in  TAG_W  tag returned with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  DATA_W  result.
- out_overflow  out  1  signed overflow (ADD/SUB only, else 0).
- out_err  out  1  unsupported opcode.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - out_valid, out_result, out_overflow, out_err, out_tag, busy all 0.
  - in_ready=1 once rst=1.
- Handshake:
  - Accept when in_valid & in_ready.
  - in_ready = !abort & (state==IDLE | (state==DONE & out_ready)).
  - Result transfer when out_valid & out_ready.
  - Outputs are held stable while out_valid=1 and out_ready=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, accept of a single-cycle op: compute, register outputs -> DONE.
  - IDLE, accept of MUL/CRC: latch operands, cnt=0 -> BUSY.
  - BUSY: one bit per cycle, cnt++. At cnt==DATA_W-1, register result -> DONE.
  - DONE: out_valid=1.
    - out_ready without a new accept -> IDLE.
    - out_ready with a new accept in the same cycle -> back-to-back, handled as an accept from IDLE.
- Latency (accept edge to out_valid):
  - 1 cycle for single-cycle ops.
  - DATA_W+1 cycles for MUL/CRC.
- abort=1: next edge state=IDLE, out_valid=0, the result is dropped. Abort wins over a simultaneous accept or transfer.
- Opcodes (widths per DATA_W):
  - 0 ADD/SUB: funct[0]=0 ADD, 1 SUB. Modulo 2^DATA_W. out_overflow = signed overflow.
  - 1 Logic, by funct: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 ANDN (a&~b), others 0.
  - 2 Compare, by funct: 0 EQ, 1 NE, 2 LT, 3 LTU, 4 GE, 5 GEU. Result zero-extended 1 bit. Others 0.
  - 3 Shift: amount = b[log2(DATA_W)-1:0]. funct: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, others 0.
  - 9 MUL, unsigned, iterative shift-add:
    - funct[0]=1 carry-less (XOR accumulate).
    - funct[1]=0 low DATA_W bits, 1 high DATA_W bits of the 2*DATA_W product.
  - 10 CRC, bitwise on in_a with init c=0:
    - funct[0]=0 MSB-first, 1 LSB-first.
    - Per bit d: fb = c[KEY_W-1]^d; c = (c<<1) ^ (fb ? key : 0).
    - Result = c zero-extended.
  - Others: single-cycle, out_result=0, out_err=1.
- out_tag = in_tag of the accepted request.
- Operands are latched at accept; input changes during BUSY have no effect.
- Reset asserted mid-BUSY: immediate IDLE, all outputs 0.

Test Plan:
- Reset, then ADD a=0x7FFFFFFF b=1 tag=3, out_ready=1 -> next cycle out_valid=1, result=0x80000000, overflow=1, tag=3; in_ready=1 the following cycle.
- MUL funct=2 a=b=0xFFFFFFFF -> out_valid exactly 33 cycles after accept, result=0xFFFFFFFE. Repeat with funct=0 -> 0x00000001. CLMUL funct=1 a=3 b=3 -> 0x5. in_ready=0 throughout BUSY.
- CRC KEY_W=8 key=0x07, funct=0: a=0x00000001 -> 0x07; a=0x00000080 -> 0x89.
- Backpressure: SUB a=5 b=7, out_ready=0 for 4 cycles -> result 0xFFFFFFFE held stable, in_ready=0. Then out_ready=1 with a new in_valid (XOR 0xF0^0xFF) -> accepted the same cycle, next result 0x0F on the following cycle.
- Abort at cnt=10 of a CRC -> next cycle state=IDLE, out_valid never asserts. Abort with in_valid=1 in the same cycle -> request not accepted (in_ready=0).
- Opcode 0xF -> out_err=1, result=0. Async rst low mid-MUL -> outputs 0 immediately, busy=0.
